// File: rtl/alu_ctrl_pkg.sv
// Shared constants and types for the ALU control unit: ALU codes, ALUOp and
// func encodings, mul/div operation encoding and sequencer states.
package alu_ctrl_pkg;

  localparam int unsigned ALU_W = 4;

  localparam logic [3:0] ALU_AND     = 4'b0000;
  localparam logic [3:0] ALU_OR      = 4'b0001;
  localparam logic [3:0] ALU_ADD     = 4'b0010;
  localparam logic [3:0] ALU_XOR     = 4'b0011;
  localparam logic [3:0] ALU_SUB     = 4'b0110;
  localparam logic [3:0] ALU_SLT     = 4'b0111;
  localparam logic [3:0] ALU_SLL     = 4'b1000;
  localparam logic [3:0] ALU_SRL     = 4'b1001;
  localparam logic [3:0] ALU_SRA     = 4'b1010;
  localparam logic [3:0] ALU_SLTU    = 4'b1011;
  localparam logic [3:0] ALU_NOR     = 4'b1100;
  localparam logic [3:0] ALU_LUI     = 4'b1101;
  localparam logic [3:0] ALU_INVALID = 4'b1111;

  localparam logic [2:0] AOP_ADD  = 3'b000;
  localparam logic [2:0] AOP_SUB  = 3'b001;
  localparam logic [2:0] AOP_FUNC = 3'b010;
  localparam logic [2:0] AOP_AND  = 3'b011;
  localparam logic [2:0] AOP_OR   = 3'b100;
  localparam logic [2:0] AOP_SLT  = 3'b101;
  localparam logic [2:0] AOP_LUI  = 3'b110;
  localparam logic [2:0] AOP_XOR  = 3'b111;

  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [1:0] MF_ALU = 2'b00;
  localparam logic [1:0] MF_HI  = 2'b01;
  localparam logic [1:0] MF_LO  = 2'b10;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic is_div(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/alu_func_decode.sv
// Pure combinational ALUOp/func decode into ALU code, illegal flag,
// result-mux select and mul/div classification.
module alu_func_decode
  import alu_ctrl_pkg::*;
(
  input  logic [2:0]       i_alu_op,
  input  logic [5:0]       i_func,
  output logic [ALU_W-1:0] o_alu_ctrl,
  output logic             o_illegal,
  output logic [1:0]       o_mf_sel,
  output logic             o_is_md,
  output md_op_e           o_md_op
);

  always_comb begin
    o_alu_ctrl = ALU_ADD;
    o_illegal  = 1'b0;
    o_mf_sel   = MF_ALU;
    o_is_md    = 1'b0;
    o_md_op    = MD_MULT;
    case (i_alu_op)
      AOP_ADD: o_alu_ctrl = ALU_ADD;
      AOP_SUB: o_alu_ctrl = ALU_SUB;
      AOP_AND: o_alu_ctrl = ALU_AND;
      AOP_OR:  o_alu_ctrl = ALU_OR;
      AOP_SLT: o_alu_ctrl = ALU_SLT;
      AOP_LUI: o_alu_ctrl = ALU_LUI;
      AOP_XOR: o_alu_ctrl = ALU_XOR;
      AOP_FUNC: begin
        case (i_func)
          F_ADD, F_ADDU: o_alu_ctrl = ALU_ADD;
          F_SUB, F_SUBU: o_alu_ctrl = ALU_SUB;
          F_AND:         o_alu_ctrl = ALU_AND;
          F_OR:          o_alu_ctrl = ALU_OR;
          F_XOR:         o_alu_ctrl = ALU_XOR;
          F_NOR:         o_alu_ctrl = ALU_NOR;
          F_SLT:         o_alu_ctrl = ALU_SLT;
          F_SLTU:        o_alu_ctrl = ALU_SLTU;
          F_SLL:         o_alu_ctrl = ALU_SLL;
          F_SRL:         o_alu_ctrl = ALU_SRL;
          F_SRA:         o_alu_ctrl = ALU_SRA;
          F_MFHI:        o_mf_sel   = MF_HI;
          F_MFLO:        o_mf_sel   = MF_LO;
          // Mul/div keep ALU=ADD; the sequencer owns the multi-cycle work
          F_MULT: begin
            o_is_md = 1'b1;
            o_md_op = MD_MULT;
          end
          F_MULTU: begin
            o_is_md = 1'b1;
            o_md_op = MD_MULTU;
          end
          F_DIV: begin
            o_is_md = 1'b1;
            o_md_op = MD_DIV;
          end
          F_DIVU: begin
            o_is_md = 1'b1;
            o_md_op = MD_DIVU;
          end
          default: begin
            o_alu_ctrl = ALU_INVALID;
            o_illegal  = 1'b1;
          end
        endcase
      end
      default: o_alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_control_seq.sv
// ALU control unit: zero-latency decode plus a MULT/DIV sequencer that stalls
// the datapath, launches the mul/div unit and pulses the HI/LO write.
module alu_control_seq
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [2:0]      alu_op_i,
  input  logic [5:0]      func_i,
  output logic [OP_W-1:0] alu_ctrl_o,
  output logic            illegal_o,
  output logic            stall_o,
  output logic            md_start_o,
  output logic [1:0]      md_op_o,
  output logic            hilo_we_o,
  output logic [1:0]      mf_sel_o
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [ALU_W-1:0] w_alu_ctrl;
  logic             w_illegal;
  logic             w_is_md;
  md_op_e           w_md_op;
  logic             w_accept;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_md_start;
  md_op_e           r_md_op;
  logic             r_hilo_we;

  alu_func_decode u_decode (
    .i_alu_op   (alu_op_i),
    .i_func     (func_i),
    .o_alu_ctrl (w_alu_ctrl),
    .o_illegal  (w_illegal),
    .o_mf_sel   (mf_sel_o),
    .o_is_md    (w_is_md),
    .o_md_op    (w_md_op)
  );

  assign alu_ctrl_o = OP_W'(w_alu_ctrl);
  assign illegal_o  = valid_i & w_illegal;

  // Only IDLE accepts; a held instruction seen in BUSY/DONE is never relaunched
  assign w_accept = (r_state == ST_IDLE) & valid_i & w_is_md;
  assign stall_o  = ~rst & (w_accept | (r_state == ST_BUSY));

  assign md_start_o = r_md_start;
  assign md_op_o    = r_md_op;
  assign hilo_we_o  = r_hilo_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_md_start <= 1'b0;
      r_md_op    <= MD_MULT;
      r_hilo_we  <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      r_hilo_we  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state    <= ST_BUSY;
            r_cnt      <= is_div(w_md_op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
            r_md_op    <= w_md_op;
            r_md_start <= 1'b1;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state   <= ST_DONE;
            r_hilo_we <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_seq.sv
// Randomized bench for alu_control_seq against a cycle-schedule reference model.
module tb_alu_control_seq;

  localparam int unsigned OP_W    = 4;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 32;

  typedef struct packed {
    logic [3:0] code;
    logic       ill;
    logic [1:0] mf;
    logic       md;
  } dec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid_i = 1'b0;
  logic [2:0]      alu_op_i = 3'b000;
  logic [5:0]      func_i = 6'b100000;
  logic [OP_W-1:0] alu_ctrl_o;
  logic            illegal_o;
  logic            stall_o;
  logic            md_start_o;
  logic [1:0]      md_op_o;
  logic            hilo_we_o;
  logic [1:0]      mf_sel_o;

  always #5 clk = ~clk;

  alu_control_seq #(.OP_W(OP_W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .alu_op_i   (alu_op_i),
    .func_i     (func_i),
    .alu_ctrl_o (alu_ctrl_o),
    .illegal_o  (illegal_o),
    .stall_o    (stall_o),
    .md_start_o (md_start_o),
    .md_op_o    (md_op_o),
    .hilo_we_o  (hilo_we_o),
    .mf_sel_o   (mf_sel_o)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Decode table straight from the opcode listing
  function automatic dec_t ref_decode(input logic [2:0] op, input logic [5:0] fn);
    dec_t d;
    d = '{code: 4'b0010, ill: 1'b0, mf: 2'b00, md: 1'b0};
    case (op)
      3'b000: d.code = 4'b0010;
      3'b001: d.code = 4'b0110;
      3'b011: d.code = 4'b0000;
      3'b100: d.code = 4'b0001;
      3'b101: d.code = 4'b0111;
      3'b110: d.code = 4'b1101;
      3'b111: d.code = 4'b0011;
      default: begin
        case (fn)
          6'b100000, 6'b100001: d.code = 4'b0010;
          6'b100010, 6'b100011: d.code = 4'b0110;
          6'b100100: d.code = 4'b0000;
          6'b100101: d.code = 4'b0001;
          6'b100110: d.code = 4'b0011;
          6'b100111: d.code = 4'b1100;
          6'b101010: d.code = 4'b0111;
          6'b101011: d.code = 4'b1011;
          6'b000000: d.code = 4'b1000;
          6'b000010: d.code = 4'b1001;
          6'b000011: d.code = 4'b1010;
          6'b010000: d.mf = 2'b01;
          6'b010010: d.mf = 2'b10;
          6'b011000, 6'b011001, 6'b011010, 6'b011011: d.md = 1'b1;
          default: begin
            d.code = 4'b1111;
            d.ill  = 1'b1;
          end
        endcase
      end
    endcase
    return d;
  endfunction

  // Model: the accept cycle fixes the whole schedule of the sequence
  int         acc_cyc = -1;
  int         acc_lat = 0;
  logic [1:0] md_op_exp = 2'b00;
  bit         chk_en = 1'b0;
  dec_t       d_exp;
  logic       busy_exp, done_exp, start_exp, stall_exp;

  assign d_exp     = ref_decode(alu_op_i, func_i);
  assign busy_exp  = (acc_cyc >= 0) && (cyc > acc_cyc) && (cyc <= acc_cyc + acc_lat);
  assign done_exp  = (acc_cyc >= 0) && (cyc == acc_cyc + acc_lat + 1);
  assign start_exp = (acc_cyc >= 0) && (cyc == acc_cyc + 1);
  assign stall_exp = !rst && (busy_exp || ((acc_cyc < 0) && valid_i && d_exp.md));

  always @(posedge clk) begin
    if (rst) begin
      acc_cyc   <= -1;
      md_op_exp <= 2'b00;
      chk_en    <= 1'b1;
    end else if (acc_cyc < 0) begin
      if (valid_i && d_exp.md) begin
        acc_cyc   <= cyc;
        acc_lat   <= (func_i[1] == 1'b1) ? int'(DIV_LAT) : int'(MUL_LAT);
        md_op_exp <= func_i[1:0];
      end
    end else if (cyc == acc_cyc + acc_lat + 1) begin
      acc_cyc <= -1;
    end
    cyc <= cyc + 1;
  end

  int stall_cnt = 0;
  int hilo_cnt = 0;
  int start_cnt = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_ctrl", 32'(alu_ctrl_o), 32'(d_exp.code));
      chk("illegal", 32'(illegal_o), 32'(valid_i & d_exp.ill));
      chk("mf_sel", 32'(mf_sel_o), 32'(d_exp.mf));
      chk("stall", 32'(stall_o), 32'(stall_exp));
      chk("md_start", 32'(md_start_o), 32'(start_exp));
      chk("hilo_we", 32'(hilo_we_o), 32'(done_exp));
      chk("md_op", 32'(md_op_o), 32'(md_op_exp));
    end
    stall_cnt <= stall_cnt + int'(stall_o);
    hilo_cnt  <= hilo_cnt + int'(hilo_we_o);
    start_cnt <= start_cnt + int'(md_start_o);
  end

  // Caller sits just after a rising edge; returns just after the edge of the next idle cycle
  task automatic issue(input logic [2:0] op, input logic [5:0] fn, input logic v);
    bit done;
    alu_op_i = op;
    func_i   = fn;
    valid_i  = v;
    @(posedge clk); #1;
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      if (acc_cyc < 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("issue_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] ftab [19] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                            6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                            6'b000000, 6'b000010, 6'b000011, 6'b010000, 6'b010010,
                            6'b011000, 6'b011001, 6'b011010, 6'b011011};
  logic [3:0] ctab [19] = '{4'b0010, 4'b0010, 4'b0110, 4'b0110, 4'b0000,
                            4'b0001, 4'b0011, 4'b1100, 4'b0111, 4'b1011,
                            4'b1000, 4'b1001, 4'b1010, 4'b0010, 4'b0010,
                            4'b0010, 4'b0010, 4'b0010, 4'b0010};
  logic [1:0] mtab [19] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                            2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10,
                            2'b00, 2'b00, 2'b00, 2'b00};
  logic [3:0] atab [8]  = '{4'b0010, 4'b0110, 4'b0010, 4'b0000,
                            4'b0001, 4'b0111, 4'b1101, 4'b0011};

  int s0, h0, m0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_md_start", 32'(md_start_o), 32'd0);
    chk("rst_md_op", 32'(md_op_o), 32'd0);
    chk("rst_hilo_we", 32'(hilo_we_o), 32'd0);

    // ALUOp sweep with func 100000
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b1; alu_op_i = 3'(i); func_i = 6'b100000;
      #2;
      chk("aluop_sweep", 32'(alu_ctrl_o), 32'(atab[i]));
      chk("aluop_sweep_ill", 32'(illegal_o), 32'd0);
    end

    // Func sweep with valid low so mul/div funcs are not launched
    for (int i = 0; i < 19; i++) begin
      @(posedge clk); #1;
      valid_i = 1'b0; alu_op_i = 3'b010; func_i = ftab[i];
      #2;
      chk("func_sweep", 32'(alu_ctrl_o), 32'(ctab[i]));
      chk("func_sweep_mf", 32'(mf_sel_o), 32'(mtab[i]));
      chk("func_sweep_ill", 32'(illegal_o), 32'd0);
    end
    @(posedge clk); #1;
    valid_i = 1'b1; alu_op_i = 3'b010; func_i = 6'b111111;
    #2;
    chk("illegal_code", 32'(alu_ctrl_o), 32'hf);
    chk("illegal_flag", 32'(illegal_o), 32'd1);
    @(posedge clk); #1;
    idle(2);

    // MULT: five stall cycles, one launch, one HI/LO write
    s0 = stall_cnt; h0 = hilo_cnt; m0 = start_cnt;
    issue(3'b010, 6'b011000, 1'b1);
    idle(3);
    chk("mult_stall_len", 32'(stall_cnt - s0), 32'd5);
    chk("mult_hilo_cnt", 32'(hilo_cnt - h0), 32'd1);
    chk("mult_start_cnt", 32'(start_cnt - m0), 32'd1);
    chk("mult_md_op", 32'(md_op_o), 32'd0);

    // DIVU: 33 stall cycles
    s0 = stall_cnt; h0 = hilo_cnt;
    issue(3'b010, 6'b011011, 1'b1);
    idle(3);
    chk("divu_stall_len", 32'(stall_cnt - s0), 32'd33);
    chk("divu_hilo_cnt", 32'(hilo_cnt - h0), 32'd1);
    chk("divu_md_op", 32'(md_op_o), 32'd3);

    // MULT then MFLO back to back
    m0 = start_cnt;
    issue(3'b010, 6'b011000, 1'b1);
    alu_op_i = 3'b010; func_i = 6'b010010; valid_i = 1'b1;
    #2;
    chk("mflo_after_mult", 32'(mf_sel_o), 32'd2);
    chk("mflo_no_stall", 32'(stall_o), 32'd0);
    #1;
    issue(3'b010, 6'b010010, 1'b1);
    idle(2);
    chk("mult_single_launch", 32'(start_cnt - m0), 32'd1);

    // Reset two cycles into a MULT
    h0 = hilo_cnt;
    alu_op_i = 3'b010; func_i = 6'b011000; valid_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; valid_i = 1'b0;
    #2;
    chk("rst_mid_stall", 32'(stall_o), 32'd0);
    chk("rst_mid_md_op", 32'(md_op_o), 32'd0);
    #1;
    idle(8);
    chk("rst_mid_no_hilo", 32'(hilo_cnt - h0), 32'd0);

    // Randomized traffic; the instruction is held while a sequence is in flight
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (acc_cyc < 0) begin
        valid_i  = ($urandom_range(0, 3) != 0);
        alu_op_i = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'($urandom_range(0, 7));
        func_i   = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                : ftab[$urandom_range(0, 18)];
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
